// File: rtl/latch_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : latch_bank_sequencer
//  Description : Round-robin sequencer sharing one transparent latch bank
//                between NREQ requesters using a setup/enable/hold sequence.
//                Optional latch readback check: define LBS_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module latch_bank_sequencer #(
   parameter int NREQ      = 4,
   parameter int W         = 8,
   parameter int SETUP_CYC = 1,
   parameter int EN_CYC    = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [W-1:0]      latch_d,
   output logic              latch_en,
   input  logic [W-1:0]      latch_q,
   output logic              busy,
   output logic              err
);

   localparam int c_MAX_SE = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int c_MAX    = (c_MAX_SE > HOLD_CYC) ? c_MAX_SE : HOLD_CYC;
   localparam int c_CW     = $clog2(c_MAX + 1);
   localparam int c_PW     = $clog2(NREQ);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_SETUP  = 3'd1;
   localparam logic [2:0] c_ENABLE = 3'd2;
   localparam logic [2:0] c_HOLD   = 3'd3;
   localparam logic [2:0] c_DONE   = 3'd4;

   localparam logic [c_CW-1:0] c_SETUP_LD = c_CW'(SETUP_CYC - 1);
   localparam logic [c_CW-1:0] c_EN_LD    = c_CW'(EN_CYC - 1);
   localparam logic [c_CW-1:0] c_HOLD_LD  = c_CW'(HOLD_CYC - 1);

   logic [2:0]      r_state, w_state_nxt;
   logic [c_CW-1:0] r_cnt, w_cnt_nxt;
   logic [c_PW-1:0] r_rr_ptr, w_win, w_rr_nxt;
   logic            w_any, w_accept;
   logic [NREQ-1:0] r_gnt, r_done, w_gnt_nxt, w_done_nxt;
   logic [W-1:0]    r_latch_d;
   logic            r_latch_en, r_busy, w_latch_en_nxt, w_busy_nxt;

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin : p_arb
      int idx;
      idx   = 0;
      w_any = 1'b0;
      w_win = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = int'(r_rr_ptr) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[c_PW'(idx)]) begin
            w_any = 1'b1;
            w_win = c_PW'(idx);
         end
      end
   end

   assign w_accept = (r_state == c_IDLE) && w_any;
   assign w_rr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + c_PW'(1);

   // Next-state logic; the counter is loaded on phase entry and counts to 0.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_IDLE: begin
            if (w_any) begin
               w_state_nxt = c_SETUP;
               w_cnt_nxt   = c_SETUP_LD;
            end
         end
         c_SETUP: begin
            if (r_cnt == '0) begin
               w_state_nxt = c_ENABLE;
               w_cnt_nxt   = c_EN_LD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         c_ENABLE: begin
            if (r_cnt == '0) begin
               w_state_nxt = c_HOLD;
               w_cnt_nxt   = c_HOLD_LD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         c_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = c_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         c_DONE:  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so latch_en is glitch-free.
   always_comb begin
      w_latch_en_nxt = (w_state_nxt == c_ENABLE);
      w_busy_nxt     = (w_state_nxt != c_IDLE);
      w_done_nxt     = (w_state_nxt == c_DONE) ? r_gnt : '0;
      w_gnt_nxt      = r_gnt;
      if (w_accept)
         w_gnt_nxt = NREQ'(1) << w_win;
      else if (r_state == c_DONE)
         w_gnt_nxt = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_IDLE;
         r_cnt      <= '0;
         r_rr_ptr   <= '0;
         r_gnt      <= '0;
         r_done     <= '0;
         r_latch_d  <= '0;
         r_latch_en <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_gnt      <= w_gnt_nxt;
         r_done     <= w_done_nxt;
         r_latch_en <= w_latch_en_nxt;
         r_busy     <= w_busy_nxt;
         if (w_accept) begin
            r_latch_d <= wdata[int'(w_win)*W +: W];
            r_rr_ptr  <= w_rr_nxt;
         end
      end
   end

`ifdef LBS_READBACK_EN
   logic r_err;

   // Compare on the last HOLD cycle, when the latch has been closed with D stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else if ((r_state == c_HOLD) && (r_cnt == '0) && (latch_q != r_latch_d))
         r_err <= 1'b1;
   end

   assign err = r_err;
`else
   wire w_unused_latch_q = ^latch_q;
   assign err = 1'b0;
`endif

   assign gnt      = r_gnt;
   assign done     = r_done;
   assign latch_d  = r_latch_d;
   assign latch_en = r_latch_en;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: doc/latch_bank_sequencer.md
# latch_bank_sequencer

Round-robin sequencer that shares a single W-bit transparent D-latch bank between NREQ requesters. It captures the granted requester's data and drives the latch data and enable pins through a fixed setup / enable / hold sequence, so the latch is never opened while its D input is changing. It then reports completion to the requester. It sits between the requester logic and the latch bank in the user project top level.

## Interface
- NREQ, 4: number of requesters, 2..8
- W, 8: latch data width
- SETUP_CYC, 1: cycles latch_d is stable before latch_en rises, >=1
- EN_CYC, 2: cycles latch_en is held high, >=1
- HOLD_CYC, 1: cycles latch_d is held after latch_en falls, >=1

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester write request, level
- wdata  in  NREQ*W  requester i data at bits [i*W +: W]
- gnt  out  NREQ  one-hot grant, high for the whole transaction
- done  out  NREQ  one-cycle completion pulse to the granted requester
- latch_d  out  W  registered data to the latch D pins
- latch_en  out  1  registered latch enable; latch is transparent while high
- latch_q  in  W  latch Q readback, used only with readback enabled
- busy  out  1  high in every state except IDLE
- err  out  1  sticky readback mismatch flag

## Operation
- States: IDLE, SETUP, ENABLE, HOLD, DONE. One down-counter, sized clog2(max(SETUP_CYC, EN_CYC, HOLD_CYC)+1), times each phase.
- IDLE: if any req bit is high, pick a winner by round-robin.
  - The search starts at rr_ptr and wraps modulo NREQ.
  - On the accepting edge: set gnt[winner]; load latch_d from the winner's wdata slice; set rr_ptr to (winner+1) mod NREQ; go to SETUP.
- SETUP: latch_en=0; stay SETUP_CYC cycles, then go to ENABLE.
- ENABLE: latch_en=1; stay EN_CYC cycles, then go to HOLD.
- HOLD: latch_en=0; latch_d is unchanged; stay HOLD_CYC cycles, then go to DONE.
- DONE: done[winner]=1 for exactly this cycle; gnt clears on the exit edge; go to IDLE.
- latch_d is captured only at grant. Changes on wdata or req during a transaction are ignored.
- A req dropped mid-transaction does not abort it; done still pulses.
- Req bits held high after done are re-arbitrated in the next IDLE cycle. The requester must drop req within the done cycle to avoid a second write.
- Reset values:
  - state=IDLE, rr_ptr=0
  - gnt=0, done=0, latch_en=0, latch_d=0, busy=0, err=0
- Reset mid-transaction: latch_en drops immediately (asynchronous); no done pulse is issued.

## Timing
- A request is accepted on edge k while in IDLE. gnt and latch_d are valid after edge k.
- latch_en is high for cycles k+SETUP_CYC .. k+SETUP_CYC+EN_CYC-1.
- done is high in cycle k+SETUP_CYC+EN_CYC+HOLD_CYC.
- IDLE lasts at least 1 cycle between transactions. Back-to-back period = SETUP_CYC+EN_CYC+HOLD_CYC+2 cycles; with defaults this is 6.
- Simultaneous requests: at most one grant at a time. Losing requesters wait without losing their request.
- All outputs are registered; there is no combinational path from req to gnt.

## Configuration
- LBS_READBACK_EN defined:
  - On the final HOLD cycle, latch_q is compared with latch_d.
  - On mismatch, err is set; it clears only on rst.
  - done still pulses and the sequence timing is unchanged.
- LBS_READBACK_EN undefined: err is tied to 0, latch_q is ignored, and no compare logic is present.

## Test plan
- Single request, defaults: req=4'b0001, wdata[7:0]=8'hA5 accepted at edge k.
  - latch_d=8'hA5 from k; latch_en high at k+1..k+2; done=4'b0001 at k+4; busy low at k+5.
- Round-robin: req=4'b1111 held through three transactions starting from reset.
  - Grant order is 0, 1, 2.
  - Then with req=4'b1001, the next grant is 3, then 0.
- Data stability: wdata[7:0] changes from 8'h3C to 8'hFF after the grant edge, and req drops during ENABLE.
  - latch_d stays 8'h3C and done still pulses.
- Reset in ENABLE: assert rst mid-pulse.
  - latch_en, gnt and busy go to 0 immediately; no done pulse; the next request is granted from rr_ptr=0.
- Readback (LBS_READBACK_EN defined):
  - latch_q=latch_d gives err=0.
  - Forcing latch_q=8'h00 against latch_d=8'h5A sets err=1, and err stays 1 through later good transactions until rst.
- Parameter sweep: SETUP_CYC=2, EN_CYC=1, HOLD_CYC=3.
  - latch_en is high only in cycle k+2; done at k+6; back-to-back period 8.
